eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Shares the single Ethernet TX MAC byte stream between two frame sources: port 0 (ARP responder) and port 1 (IPv4/UDP transmit path).
- Grants are frame-granular: round-robin between ports, and only one frame is forwarded at a time.
- Enforces an inter-frame gap after every frame.
- Guards against runaway sources with a maximum-length watchdog.
- Sits between the protocol TX engines and the MAC/preamble inserter, mirroring the RX-side SoF/EoF/Val/Data byte convention.

Parameters:
- IFG_CYCLES, 12, idle cycles enforced after each frame's EoF before the next grant.
- MAX_BYTES, 1530, maximum bytes forwarded per frame before a forced abort.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Req  in  2  per-port frame-ready request; bit n = port n.
- Gnt  out  2  one-hot grant, registered.
- SoFIn0/EoFIn0/ValIn0  in  1 each  port 0 frame strobes.
- DataIn0  in  8  port 0 byte.
- SoFIn1/EoFIn1/ValIn1  in  1 each  port 1 frame strobes.
- DataIn1  in  8  port 1 byte.
- SoFOut  out  1  first byte of the forwarded frame.
- EoFOut  out  1  last byte of the forwarded frame.
- ValOut  out  1  byte valid toward the MAC.
- DataOut  out  8  forwarded byte.
- ErrOut  out  1  one-cycle pulse on a watchdog abort.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset and interface:
  - Clock port is Clk; reset port is Rst, synchronous and active-high. One clock domain.
  - Reset values: all outputs 0, state IDLE, round-robin pointer favours port 0 first, byte counter 0, IFG counter 0.
  - Reset mid-frame: outputs drop to 0 on the next edge. No EoF is emitted for the truncated frame.
- Backpressure: none. The MAC accepts one byte on every cycle ValOut=1. Sources may insert gaps by deasserting Val.
- States: IDLE, XFER, DRAIN, IFG.
- IDLE:
  - No Req: stay in IDLE.
  - One Req bit set: grant that port.
  - Both set: grant the port not granted last (round-robin).
  - Gnt asserts on the edge after the decision; state moves to XFER on that same edge.
- XFER:
  - Input bytes from the granted port with Val=1 are forwarded, registered, with 1-cycle latency: DataOut/ValOut/SoFOut/EoFOut equal the granted inputs delayed one clock.
  - Non-granted port inputs are ignored completely.
  - Valid bytes before the first SoF&Val are discarded (not forwarded, not counted).
  - The byte counter increments on each forwarded byte.
  - EoF&Val forwarded: Gnt clears on the next edge, the pointer updates to the other port, and the state moves to IFG.
  - SoF&Val on the same byte as EoF: treated as a 1-byte frame; both SoFOut and EoFOut are set.
  - Req deasserted during XFER is ignored; the frame completes.
- Watchdog:
  - The abort triggers when the counter reaches MAX_BYTES and the byte being forwarded is not EoF.
  - That byte goes out with EoFOut=1 forced.
  - ErrOut pulses for 1 cycle, aligned with that EoFOut.
  - Gnt stays set; state moves to DRAIN.
- DRAIN: the granted source's bytes are discarded with nothing forwarded. On its EoF&Val, Gnt clears and the state moves to IFG.
- IFG:
  - The counter loads IFG_CYCLES-1 on entry and decrements each cycle; at 0 the state moves to IDLE.
  - The first new Gnt can occur no earlier than IFG_CYCLES+1 cycles after the EoFOut cycle.
  - IFG_CYCLES=0 is legal: IFG lasts one cycle.
- Widths:
  - Byte counter is 11 bits, saturating, and clears on IFG entry.
  - IFG counter is ceil(log2(IFG_CYCLES+1)) bits, minimum 1.
- Gnt is always one-hot or zero; it is never 2'b11.

Optional Feature:
- Macro: ETH_TX_ARB_ARP_PRIORITY_EN.
- Defined: port 0 (ARP) wins whenever both Req bits are set in IDLE, regardless of the pointer. Port 1 can starve if port 0 requests continuously.
- Undefined: pure round-robin as described above.
- IFG and watchdog behaviour are identical either way.

Test Plan:
1. Req=01; port 0 sends a 60-byte frame (SoF on byte 0, EoF on byte 59) -> Gnt=01 one cycle later; DataOut reproduces all 60 bytes with 1-cycle latency; exactly one SoFOut and one EoFOut; Gnt=00 the cycle after EoF.
2. Req=11 held, both ports stream 64-byte frames -> grant order 0,1,0,1. Each gap from EoFOut to the next SoFOut is at least 13 cycles with IFG_CYCLES=12. With the macro defined the order is 0,0,0.
3. Port 1 granted, sends 1600 bytes without EoF, MAX_BYTES=1530 -> byte 1530 carries EoFOut=1 and ErrOut=1 for one cycle. No ValOut until port 1's EoF arrives, then IFG.
4. Granted port sends 3 Val bytes before SoF, then a frame with Val gaps of 2 cycles -> leading 3 bytes dropped; ValOut mirrors the gaps; byte count is correct.
5. Rst asserted on byte 20 of a frame -> next edge: ValOut=0, Gnt=00, Busy=0. After release with Req=10, port 1 is granted normally.
6. Single byte with SoF=EoF=Val=1 -> one ValOut cycle with SoFOut=EoFOut=1, followed by IFG.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter
//
// Shares one Ethernet TX MAC byte stream between two frame sources:
//   port 0 = ARP responder, port 1 = IPv4/UDP transmit path.
// Grants cover a whole frame. Ports take turns (round-robin) when both
// request. Every frame is followed by an inter-frame gap. A watchdog cuts
// off any frame that runs past MAX_BYTES.
//
// Build option:
//   ETH_TX_ARB_ARP_PRIORITY_EN - when defined, port 0 always wins a
//                                simultaneous request in IDLE. Port 1 can
//                                starve if port 0 keeps requesting.
//
// Parameters:
//   IFG_CYCLES - idle cycles enforced after each frame's EoF (0 is legal).
//   MAX_BYTES  - bytes forwarded per frame before a forced abort.
//
// Ports:
//   Clk, Rst        - clock; synchronous active-high reset.
//   Req[1:0]        - per-port frame-ready request.
//   Gnt[1:0]        - registered one-hot grant (never 2'b11).
//   SoFIn0/EoFIn0/ValIn0/DataIn0 - port 0 byte stream.
//   SoFIn1/EoFIn1/ValIn1/DataIn1 - port 1 byte stream.
//   SoFOut/EoFOut/ValOut/DataOut - forwarded stream, one cycle of latency.
//   ErrOut          - one-cycle pulse aligned with a forced EoFOut.
//   Busy            - high in every state except IDLE.
// -----------------------------------------------------------------------------
module eth_tx_arbiter #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_BYTES  = 1530
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] Req,
  output logic [1:0] Gnt,
  input  logic       SoFIn0,
  input  logic       EoFIn0,
  input  logic       ValIn0,
  input  logic [7:0] DataIn0,
  input  logic       SoFIn1,
  input  logic       EoFIn1,
  input  logic       ValIn1,
  input  logic [7:0] DataIn1,
  output logic       SoFOut,
  output logic       EoFOut,
  output logic       ValOut,
  output logic [7:0] DataOut,
  output logic       ErrOut,
  output logic       Busy
);

  localparam int IFG_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  // With IFG_CYCLES=0 the IFG state still lasts one cycle, so the load
  // value bottoms out at 0.
  localparam logic [IFG_W-1:0] IFG_LOAD =
    IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [10:0] LAST_CNT = 11'(MAX_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DRAIN,
    ST_IFG
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             ptr_q, ptr_d;        // port favoured on the next tie
  logic [10:0]      byte_cnt_q, byte_cnt_d;
  logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
  logic             in_frame_q, in_frame_d; // SoF already seen this grant
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             val_q, val_d;
  logic [7:0]       data_q, data_d;
  logic             err_q, err_d;

  // Granted-port view of the inputs; the other port is never looked at.
  logic       sel_port;
  logic       sel_sof, sel_eof, sel_val;
  logic [7:0] sel_data;

  assign sel_port = gnt_q[1];
  assign sel_sof  = sel_port ? SoFIn1  : SoFIn0;
  assign sel_eof  = sel_port ? EoFIn1  : EoFIn0;
  assign sel_val  = sel_port ? ValIn1  : ValIn0;
  assign sel_data = sel_port ? DataIn1 : DataIn0;

  logic fwd;    // this byte is part of the frame and goes out
  logic abort;  // this byte reaches MAX_BYTES without being the EoF

  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    byte_cnt_d = byte_cnt_q;
    ifg_cnt_d  = ifg_cnt_q;
    in_frame_d = in_frame_q;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    val_d      = 1'b0;
    err_d      = 1'b0;
    data_d     = data_q;

    fwd   = (state_q == ST_XFER) && sel_val && (in_frame_q || sel_sof);
    abort = fwd && !sel_eof && (byte_cnt_q == LAST_CNT);

    unique case (state_q)
      ST_IDLE: begin
        unique case (Req)
          2'b01: gnt_d = 2'b01;
          2'b10: gnt_d = 2'b10;
`ifdef ETH_TX_ARB_ARP_PRIORITY_EN
          2'b11: gnt_d = 2'b01;
`else
          2'b11: gnt_d = ptr_q ? 2'b10 : 2'b01;
`endif
          default: gnt_d = 2'b00;
        endcase
        if (Req != 2'b00) begin
          state_d    = ST_XFER;
          byte_cnt_d = '0;
          in_frame_d = 1'b0;
        end
      end

      ST_XFER: begin
        if (fwd) begin
          val_d      = 1'b1;
          data_d     = sel_data;
          sof_d      = sel_sof;
          eof_d      = sel_eof || abort;
          err_d      = abort;
          in_frame_d = 1'b1;
          if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 11'd1;
          if (sel_eof) begin
            state_d    = ST_IFG;
            gnt_d      = 2'b00;
            ptr_d      = ~sel_port;
            ifg_cnt_d  = IFG_LOAD;
            byte_cnt_d = '0;
            in_frame_d = 1'b0;
          end else if (abort) begin
            // Grant is held so the rest of the runaway frame can be sunk.
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (sel_val && sel_eof) begin
          state_d    = ST_IFG;
          gnt_d      = 2'b00;
          ptr_d      = ~sel_port;
          ifg_cnt_d  = IFG_LOAD;
          byte_cnt_d = '0;
          in_frame_d = 1'b0;
        end
      end

      ST_IFG: begin
        if (ifg_cnt_q == '0) state_d = ST_IDLE;
        else                 ifg_cnt_d = ifg_cnt_q - IFG_W'(1);
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the values from before the edge, independent of process order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 2'b00;
      ptr_q      <= 1'b0;
      byte_cnt_q <= '0;
      ifg_cnt_q  <= '0;
      in_frame_q <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      val_q      <= 1'b0;
      data_q     <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      byte_cnt_q <= byte_cnt_d;
      ifg_cnt_q  <= ifg_cnt_d;
      in_frame_q <= in_frame_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      val_q      <= val_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign Gnt     = gnt_q;
  assign SoFOut  = sof_q;
  assign EoFOut  = eof_q;
  assign ValOut  = val_q;
  assign DataOut = data_q;
  assign ErrOut  = err_q;
  assign Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_arbiter
//
// Directed bench for eth_tx_arbiter with default parameters
// (IFG_CYCLES=12, MAX_BYTES=1530). Sources are driven just after each
// rising edge; a monitor records the forwarded stream on falling edges so
// frame contents and cycle spacing can be compared with hand-derived values.
// -----------------------------------------------------------------------------
module tb_eth_tx_arbiter;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [1:0] Req;
  logic [1:0] Gnt;
  logic       SoFIn0, EoFIn0, ValIn0;
  logic [7:0] DataIn0;
  logic       SoFIn1, EoFIn1, ValIn1;
  logic [7:0] DataIn1;
  logic       SoFOut, EoFOut, ValOut, ErrOut, Busy;
  logic [7:0] DataOut;

  eth_tx_arbiter dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Gnt(Gnt),
    .SoFIn0(SoFIn0), .EoFIn0(EoFIn0), .ValIn0(ValIn0), .DataIn0(DataIn0),
    .SoFIn1(SoFIn1), .EoFIn1(EoFIn1), .ValIn1(ValIn1), .DataIn1(DataIn1),
    .SoFOut(SoFOut), .EoFOut(EoFOut), .ValOut(ValOut), .DataOut(DataOut),
    .ErrOut(ErrOut), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] out_q[$];
  int val_cyc[$];
  int sof_cyc[$];
  int eof_cyc[$];
  int eof_idx[$];
  int err_cyc[$];
  int bad_gnt = 0;

  always @(negedge Clk) begin
    if (Gnt == 2'b11) bad_gnt++;
    if (ValOut) begin
      out_q.push_back(DataOut);
      val_cyc.push_back(cyc);
      if (SoFOut) sof_cyc.push_back(cyc);
      if (EoFOut) begin
        eof_cyc.push_back(cyc);
        eof_idx.push_back(out_q.size());
      end
    end
    if (ErrOut) err_cyc.push_back(cyc);
  end

  function automatic int qi(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int qb(logic [7:0] q[$], int i);
    return (i < q.size()) ? int'(q[i]) : -1;
  endfunction

  task automatic clear_q();
    out_q.delete(); val_cyc.delete(); sof_cyc.delete();
    eof_cyc.delete(); eof_idx.delete(); err_cyc.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic drive(int p, logic s, logic e, logic v, logic [7:0] d);
    if (p == 0) begin SoFIn0 = s; EoFIn0 = e; ValIn0 = v; DataIn0 = d; end
    else        begin SoFIn1 = s; EoFIn1 = e; ValIn1 = v; DataIn1 = d; end
  endtask

  // Called just after a rising edge; returns one cycle after the last byte
  // with the port idle, i.e. in the cycle where that byte appears at the output.
  task automatic send(int p, int n, bit sof_en, bit eof_en, int gap,
                      logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      drive(p, sof_en && (i == 0), eof_en && (i == n - 1), 1'b1, base + 8'(i));
      @(posedge Clk); #1;
      if (i != n - 1)
        for (int g = 0; g < gap; g++) begin
          drive(p, 1'b0, 1'b0, 1'b0, 8'h00);
          @(posedge Clk); #1;
        end
    end
    drive(p, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_gnt(output int p, output bit ok);
    ok = 1'b0;
    p  = 0;
    for (int i = 0; i < 100; i++) begin
      if (Gnt != 2'b00) begin
        ok = 1'b1;
        p  = Gnt[1] ? 1 : 0;
        break;
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic do_reset();
    Req = 2'b00;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    clear_q();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  int  p, g;
  bit  ok;
  int  exp_port[4];

  initial begin
`ifdef ETH_TX_ARB_ARP_PRIORITY_EN
    exp_port = '{0, 0, 0, 0};
`else
    exp_port = '{0, 1, 0, 1};
`endif

    // ---- reset state ----
    do_reset();
    check("rst_gnt",  Gnt,     2'b00);
    check("rst_val",  ValOut,  1'b0);
    check("rst_sof",  SoFOut,  1'b0);
    check("rst_eof",  EoFOut,  1'b0);
    check("rst_err",  ErrOut,  1'b0);
    check("rst_data", DataOut, 8'h00);
    check("rst_busy", Busy,    1'b0);

    // ---- 1: single 60-byte frame on port 0 ----
    Req = 2'b01;
    @(posedge Clk); #1;
    check("t1_gnt_latency", Gnt, 2'b01);
    check("t1_busy", Busy, 1'b1);
    g = cyc;
    Req = 2'b00;
    send(0, 60, 1'b1, 1'b1, 0, 8'h10);
    check("t1_eof_now", EoFOut, 1'b1);
    check("t1_gnt_clear", Gnt, 2'b00);
    repeat (3) @(posedge Clk);
    #1;
    check("t1_nbytes", out_q.size(), 60);
    for (int i = 0; i < 60; i++) check("t1_byte", qb(out_q, i), (8'h10 + i) & 8'hff);
    check("t1_nsof", sof_cyc.size(), 1);
    check("t1_neof", eof_cyc.size(), 1);
    check("t1_sof_cyc", qi(sof_cyc, 0) - g, 1);
    check("t1_eof_cyc", qi(eof_cyc, 0) - g, 60);
    check("t1_noerr", err_cyc.size(), 0);

    // ---- 2: both ports request continuously ----
    do_reset();
    Req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(p, ok);
      check("t2_gnt_wait", ok, 1'b1);
      check("t2_order", p, exp_port[k]);
      send(p, 64, 1'b1, 1'b1, 0, (p == 1) ? 8'h80 : 8'h00);
    end
    Req = 2'b00;
    repeat (3) @(posedge Clk);
    #1;
    check("t2_nbytes", out_q.size(), 256);
    for (int k = 0; k < 4; k++)
      check("t2_first_byte", qb(out_q, k * 64), (exp_port[k] == 1) ? 8'h80 : 8'h00);
    // EoFOut at E, Gnt at E+13, first byte driven then, SoFOut at E+14.
    for (int k = 1; k < 4; k++)
      check("t2_gap", qi(sof_cyc, k) - qi(eof_cyc, k - 1), 14);

    // ---- 3: watchdog abort on port 1 ----
    do_reset();
    Req = 2'b10;
    wait_gnt(p, ok);
    check("t3_gnt_wait", ok, 1'b1);
    check("t3_port", p, 1);
    Req = 2'b00;
    send(1, 1600, 1'b1, 1'b0, 0, 8'h00);
    check("t3_drain_gnt", Gnt, 2'b10);
    check("t3_drain_busy", Busy, 1'b1);
    check("t3_drain_val", ValOut, 1'b0);
    check("t3_nbytes", out_q.size(), 1530);
    check("t3_neof", eof_cyc.size(), 1);
    check("t3_eof_idx", qi(eof_idx, 0), 1530);
    check("t3_nerr", err_cyc.size(), 1);
    check("t3_err_align", qi(err_cyc, 0), qi(eof_cyc, 0));
    check("t3_last_byte", qb(out_q, 1529), 8'hF9);
    send(1, 1, 1'b0, 1'b1, 0, 8'hCC);
    check("t3_end_gnt", Gnt, 2'b00);
    check("t3_end_val", ValOut, 1'b0);
    check("t3_ifg_busy", Busy, 1'b1);
    repeat (12) @(posedge Clk);
    #1;
    check("t3_idle", Busy, 1'b0);
    check("t3_nbytes_after", out_q.size(), 1530);

    // ---- 4: leading junk, Val gaps, port 1 noise ignored ----
    do_reset();
    drive(1, 1'b1, 1'b0, 1'b1, 8'hEE);
    Req = 2'b01;
    wait_gnt(p, ok);
    check("t4_gnt_wait", ok, 1'b1);
    check("t4_port", p, 0);
    Req = 2'b00;
    send(0, 3, 1'b0, 1'b0, 0, 8'hA0);
    send(0, 5, 1'b1, 1'b1, 2, 8'hB0);
    check("t4_gnt_clear", Gnt, 2'b00);
    repeat (2) @(posedge Clk);
    #1;
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t4_nbytes", out_q.size(), 5);
    for (int i = 0; i < 5; i++) check("t4_byte", qb(out_q, i), 8'hB0 + i);
    for (int i = 1; i < 5; i++) check("t4_val_gap", qi(val_cyc, i) - qi(val_cyc, i - 1), 3);
    check("t4_nsof", sof_cyc.size(), 1);
    check("t4_neof", eof_cyc.size(), 1);

    // ---- 5: reset in the middle of a frame ----
    do_reset();
    Req = 2'b01;
    wait_gnt(p, ok);
    check("t5_gnt_wait", ok, 1'b1);
    send(0, 20, 1'b1, 1'b0, 0, 8'h40);
    check("t5_mid_val", ValOut, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b1, 8'h54);
    Rst = 1'b1;
    @(posedge Clk); #1;
    check("t5_rst_val", ValOut, 1'b0);
    check("t5_rst_eof", EoFOut, 1'b0);
    check("t5_rst_gnt", Gnt, 2'b00);
    check("t5_rst_busy", Busy, 1'b0);
    Rst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    clear_q();
    Req = 2'b10;
    @(posedge Clk); #1;
    check("t5_regrant", Gnt, 2'b10);
    Req = 2'b00;

    // ---- 6: one-byte frame on port 1 ----
    send(1, 1, 1'b1, 1'b1, 0, 8'h5A);
    check("t6_val", ValOut, 1'b1);
    check("t6_sof", SoFOut, 1'b1);
    check("t6_eof", EoFOut, 1'b1);
    check("t6_data", DataOut, 8'h5A);
    check("t6_gnt", Gnt, 2'b00);
    check("t6_busy", Busy, 1'b1);
    repeat (11) @(posedge Clk);
    #1;
    check("t6_ifg_last", Busy, 1'b1);
    @(posedge Clk); #1;
    check("t6_idle", Busy, 1'b0);
    check("t6_nbytes", out_q.size(), 1);
    check("t6_noerr", err_cyc.size(), 0);

    check("gnt_onehot", bad_gnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
